// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending panel arbiter
// Purpose: FSM state encoding, panel identifiers and the coin value encoding
// used by vend_panel_arbiter and vend_credit_acc.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    REFUND   = 2'd2
  } state_t;

  localparam logic PANEL_A = 1'b0;
  localparam logic PANEL_B = 1'b1;

  // A coin pulse carries its value in credit units; zero means no coin.
  typedef enum logic [1:0] {
    COIN_NONE  = 2'd0,
    COIN_ONE   = 2'd1,
    COIN_TWO   = 2'd2,
    COIN_THREE = 2'd3
  } coin_t;

endpackage

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - per-panel credit balance, coin reject and cancel flag
// Purpose: accumulates coin pulses into a saturating-checked balance, flags
// coins that would overflow MAX_CREDIT, and holds the pending-cancel flag.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   coin         coin value this cycle (0 = none)
//   cancel       refund request pulse, sets pend
//   clr          zero the balance this edge (the same-cycle coin is folded
//                into credit_eff so the owner captures it before the clear)
//   pend_clr     clear pend (a same-cycle cancel wins)
//   credit       registered balance
//   credit_eff   balance including this cycle's coin if it fits
//   pend         pending cancel flag
//   coin_rej     registered reject pulse for an overflowing coin
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT = 7,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          cancel,
  input  logic          clr,
  input  logic          pend_clr,
  output logic [CW-1:0] credit,
  output logic [CW-1:0] credit_eff,
  output logic          pend,
  output logic          coin_rej
);

  logic [CW:0] sum;
  logic        fits;

  // One extra bit so the overflow check itself cannot wrap.
  assign sum        = {1'b0, credit} + (CW+1)'(coin);
  assign fits       = (sum <= (CW+1)'(MAX_CREDIT));
  assign credit_eff = fits ? sum[CW-1:0] : credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit   <= '0;
      pend     <= 1'b0;
      coin_rej <= 1'b0;
    end else begin
      credit   <= clr ? '0 : credit_eff;
      coin_rej <= (coin != COIN_NONE) && !fits;
      pend     <= cancel | (pend & ~pend_clr);
    end
  end

endmodule

// File: rtl/vend_panel_arbiter.sv
// rtl/vend_panel_arbiter.sv - two-panel dispenser arbiter with credit and refunds
// Purpose: grants the shared dispenser round-robin to panels holding enough
// credit, runs the req/ack handshake with a timeout, and returns change or
// full refunds on one shared coin-return port.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   coin_a, coin_b           coin value pulses (0 = none, 1..3 units)
//   cancel_a, cancel_b       refund request pulses
//   coin_rej_a, coin_rej_b   registered coin reject pulses
//   disp_req, disp_owner     dispense request and the panel being served
//   disp_ack                 dispenser done pulse
//   vend_done                pulse on an accepted ack
//   ret_valid, ret_owner,
//   ret_amount               one-cycle coin-return transfer
//   fault                    pulse on timeout abort
module vend_panel_arbiter
  import vend_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 7,
  parameter int CW         = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin_a,
  input  logic [1:0]    coin_b,
  input  logic          cancel_a,
  input  logic          cancel_b,
  output logic          coin_rej_a,
  output logic          coin_rej_b,
  output logic          disp_req,
  output logic          disp_owner,
  input  logic          disp_ack,
  output logic          vend_done,
  output logic          ret_valid,
  output logic          ret_owner,
  output logic [CW-1:0] ret_amount,
  output logic          fault
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, state_nxt;
  logic          owner, rr;
  logic [TW-1:0] tcnt;

  logic [CW-1:0] credit_a, credit_b, eff_a, eff_b, eff_own;
  logic          pend_a, pend_b, elig_a, elig_b;

  logic          clr_a, clr_b, pclr_a, pclr_b;
  logic          load_ret, ret_own_nxt;
  logic [CW-1:0] ret_amt_nxt;
  logic          grant, grant_own, rr_nxt;
  logic          vend_nxt, fault_nxt;

  logic          ret_own_r, vend_r, fault_r;
  logic [CW-1:0] ret_amt_r;

  vend_credit_acc #(.MAX_CREDIT(MAX_CREDIT), .CW(CW)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .coin       (coin_a),
    .cancel     (cancel_a),
    .clr        (clr_a),
    .pend_clr   (pclr_a),
    .credit     (credit_a),
    .credit_eff (eff_a),
    .pend       (pend_a),
    .coin_rej   (coin_rej_a)
  );

  vend_credit_acc #(.MAX_CREDIT(MAX_CREDIT), .CW(CW)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .coin       (coin_b),
    .cancel     (cancel_b),
    .clr        (clr_b),
    .pend_clr   (pclr_b),
    .credit     (credit_b),
    .credit_eff (eff_b),
    .pend       (pend_b),
    .coin_rej   (coin_rej_b)
  );

  assign elig_a  = (credit_a >= CW'(PRICE)) && !pend_a;
  assign elig_b  = (credit_b >= CW'(PRICE)) && !pend_b;
  assign eff_own = (owner == PANEL_B) ? eff_b : eff_a;

  always_comb begin
    state_nxt   = state;
    clr_a       = 1'b0;
    clr_b       = 1'b0;
    pclr_a      = 1'b0;
    pclr_b      = 1'b0;
    load_ret    = 1'b0;
    ret_own_nxt = owner;
    ret_amt_nxt = '0;
    grant       = 1'b0;
    grant_own   = PANEL_A;
    rr_nxt      = rr;
    vend_nxt    = 1'b0;
    fault_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // Cancels outrank vends; a cancel with nothing to return is simply dropped.
        if (pend_a) begin
          pclr_a = 1'b1;
          if (eff_a != '0) begin
            clr_a       = 1'b1;
            load_ret    = 1'b1;
            ret_own_nxt = PANEL_A;
            ret_amt_nxt = eff_a;
            state_nxt   = REFUND;
          end
        end else if (pend_b) begin
          pclr_b = 1'b1;
          if (eff_b != '0) begin
            clr_b       = 1'b1;
            load_ret    = 1'b1;
            ret_own_nxt = PANEL_B;
            ret_amt_nxt = eff_b;
            state_nxt   = REFUND;
          end
        end else if (elig_a && elig_b) begin
          // The pointer only moves on a tie, so a lone grant keeps the turn order.
          grant     = 1'b1;
          grant_own = rr;
          rr_nxt    = ~rr;
          state_nxt = WAIT_ACK;
        end else if (elig_a) begin
          grant     = 1'b1;
          grant_own = PANEL_A;
          state_nxt = WAIT_ACK;
        end else if (elig_b) begin
          grant     = 1'b1;
          grant_own = PANEL_B;
          state_nxt = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // An ack on the final timeout cycle still counts as a vend.
        if (disp_ack) begin
          vend_nxt    = 1'b1;
          clr_a       = (owner == PANEL_A);
          clr_b       = (owner == PANEL_B);
          load_ret    = 1'b1;
          ret_amt_nxt = eff_own - CW'(PRICE);
          state_nxt   = (ret_amt_nxt != '0) ? REFUND : IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          fault_nxt   = 1'b1;
          clr_a       = (owner == PANEL_A);
          clr_b       = (owner == PANEL_B);
          load_ret    = 1'b1;
          ret_amt_nxt = eff_own;
          state_nxt   = REFUND;
        end
      end

      REFUND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= PANEL_A;
      rr        <= PANEL_A;
      tcnt      <= '0;
      ret_own_r <= 1'b0;
      ret_amt_r <= '0;
      vend_r    <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr      <= rr_nxt;
      vend_r  <= vend_nxt;
      fault_r <= fault_nxt;
      if (grant) begin
        owner <= grant_own;
        tcnt  <= '0;
      end else if (state == WAIT_ACK) begin
        tcnt <= tcnt + TW'(1);
      end
      if (load_ret) begin
        ret_own_r <= ret_own_nxt;
        ret_amt_r <= ret_amt_nxt;
      end
    end
  end

  assign disp_req   = (state == WAIT_ACK);
  assign disp_owner = disp_req & owner;
  assign ret_valid  = (state == REFUND);
  assign ret_owner  = ret_valid & ret_own_r;
  assign ret_amount = ret_valid ? ret_amt_r : '0;
  assign vend_done  = vend_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// tb/tb_vend_panel_arbiter.sv - scoreboard bench for vend_panel_arbiter
module tb_vend_panel_arbiter;

  localparam int EV_GRANT = 0;
  localparam int EV_VEND  = 1;
  localparam int EV_FAULT = 2;
  localparam int EV_REJ   = 3;
  localparam int EV_RET   = 4;

  typedef struct {
    int kind;
    int owner;
    int amount;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin_a = 2'd0;
  logic [1:0] coin_b = 2'd0;
  logic       cancel_a = 1'b0;
  logic       cancel_b = 1'b0;
  logic       disp_ack = 1'b0;
  logic       coin_rej_a, coin_rej_b, disp_req, disp_owner;
  logic       vend_done, ret_valid, ret_owner, fault;
  logic [2:0] ret_amount;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  logic req_prev = 1'b0;

  vend_panel_arbiter #(.PRICE(3), .MAX_CREDIT(7), .CW(3), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_a     (coin_a),
    .coin_b     (coin_b),
    .cancel_a   (cancel_a),
    .cancel_b   (cancel_b),
    .coin_rej_a (coin_rej_a),
    .coin_rej_b (coin_rej_b),
    .disp_req   (disp_req),
    .disp_owner (disp_owner),
    .disp_ack   (disp_ack),
    .vend_done  (vend_done),
    .ret_valid  (ret_valid),
    .ret_owner  (ret_owner),
    .ret_amount (ret_amount),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic push(input int kind, input int owner, input int amount);
    ev_t e;
    e.kind   = kind;
    e.owner  = owner;
    e.amount = amount;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int owner, input int amount);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d owner=%0d amount=%0d expected none",
               kind, owner, amount);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.owner != owner || e.amount != amount) begin
        errors++;
        $display("FAIL event got kind=%0d owner=%0d amount=%0d expected kind=%0d owner=%0d amount=%0d",
                 kind, owner, amount, e.kind, e.owner, e.amount);
      end
    end
  endtask

  // Monitor: one canonical order for events that share a cycle.
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (disp_req && !req_prev) observe(EV_GRANT, int'(disp_owner), 0);
      if (vend_done)             observe(EV_VEND, 0, 0);
      if (fault)                 observe(EV_FAULT, 0, 0);
      if (coin_rej_a)            observe(EV_REJ, 0, 0);
      if (coin_rej_b)            observe(EV_REJ, 1, 0);
      if (ret_valid)             observe(EV_RET, int'(ret_owner), int'(ret_amount));
      req_prev = disp_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic coins(input logic [1:0] a, input logic [1:0] b);
    coin_a = a;
    coin_b = b;
    tick();
    coin_a = 2'd0;
    coin_b = 2'd0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!disp_req && n < 20) begin
      tick();
      n++;
    end
    if (!disp_req) begin
      checks++;
      errors++;
      $display("FAIL %s got no disp_req expected disp_req within 20 cycles", name);
    end
  endtask

  task automatic do_ack();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    ticks(3);
    chk("rst_disp_req", int'(disp_req), 0);
    chk("rst_vend_done", int'(vend_done), 0);
    chk("rst_ret_valid", int'(ret_valid), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_coin_rej", int'(coin_rej_a) + int'(coin_rej_b), 0);
    chk("rst_ret_amount", int'(ret_amount), 0);
    rst = 1'b0;
    tick();

    // 2 + 1 reaches PRICE, exact-price vend gives no change
    push(EV_GRANT, 0, 0);
    coins(2'd2, 2'd0);
    coins(2'd1, 2'd0);
    wait_req("t1_req");
    push(EV_VEND, 0, 0);
    do_ack();
    ticks(2);

    // Simultaneous eligibility: A first, then B; next tie goes to B
    push(EV_GRANT, 0, 0);
    coins(2'd3, 2'd3);
    wait_req("t2_req_a");
    push(EV_VEND, 0, 0);
    do_ack();
    push(EV_GRANT, 1, 0);
    wait_req("t2_req_b");
    push(EV_VEND, 0, 0);
    do_ack();
    ticks(2);
    push(EV_GRANT, 1, 0);
    coins(2'd3, 2'd3);
    wait_req("t2_rr_b");
    push(EV_VEND, 0, 0);
    do_ack();
    push(EV_GRANT, 0, 0);
    wait_req("t2_rr_a");
    push(EV_VEND, 0, 0);
    do_ack();
    ticks(2);

    // A builds to 6 while B is served; overflowing coin rejected; change 3
    push(EV_GRANT, 1, 0);
    coins(2'd0, 2'd3);
    wait_req("t3_req_b");
    coins(2'd3, 2'd0);
    coins(2'd3, 2'd0);
    push(EV_REJ, 0, 0);
    coins(2'd2, 2'd0);
    tick();
    push(EV_VEND, 0, 0);
    do_ack();
    push(EV_GRANT, 0, 0);
    wait_req("t3_req_a");
    push(EV_VEND, 0, 0);
    push(EV_RET, 0, 3);
    do_ack();
    ticks(3);

    // No ack: request held TIMEOUT cycles, then fault with full refund 3+2
    push(EV_GRANT, 0, 0);
    push(EV_FAULT, 0, 0);
    push(EV_RET, 0, 5);
    coins(2'd3, 2'd0);
    wait_req("t4_req");
    n = 0;
    while (disp_req && n < 40) begin
      if (n == 2) coin_a = 2'd2;
      tick();
      coin_a = 2'd0;
      n++;
    end
    chk("t4_timeout_len", n, 15);
    ticks(3);

    // Cancel B during A's vend: refund follows the vend; empty cancel is silent
    push(EV_GRANT, 0, 0);
    coins(2'd3, 2'd0);
    wait_req("t5_req");
    coins(2'd0, 2'd2);
    cancel_b = 1'b1;
    tick();
    cancel_b = 1'b0;
    push(EV_VEND, 0, 0);
    push(EV_RET, 1, 2);
    do_ack();
    ticks(3);
    cancel_a = 1'b1;
    tick();
    cancel_a = 1'b0;
    ticks(4);

    // Asynchronous reset in WAIT_ACK, credits restart from 0
    push(EV_GRANT, 1, 0);
    coins(2'd0, 2'd3);
    wait_req("t6_req");
    coins(2'd2, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_disp_req", int'(disp_req), 0);
    chk("t6_async_ret_valid", int'(ret_valid), 0);
    ticks(2);
    rst = 1'b0;
    coins(2'd2, 2'd0);
    ticks(3);
    push(EV_GRANT, 0, 0);
    coins(2'd1, 2'd0);
    wait_req("t6_req_after");
    push(EV_VEND, 0, 0);
    do_ack();
    ticks(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
